// File: rtl/tmr_vote_pkg.sv
// rtl/tmr_vote_pkg.sv - shared constants and majority helper for the TMR voter
package tmr_vote_pkg;

    localparam int WID_DEF   = 5;
    localparam int CNT_W_DEF = 8;

    // Two-of-three majority of single bits; the voter applies it bit by bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_sat_cnt.sv
// rtl/tmr_sat_cnt.sv - saturating up-counter with synchronous active-high clear
module tmr_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Hold at all-ones instead of wrapping so a long fault run stays visible.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tmr_vote3.sv
// rtl/tmr_vote3.sv - registered bitwise TMR voter; VOTE_ERR_CNT_EN adds per-replica error counters
module tmr_vote3
    import tmr_vote_pkg::*;
#(
    parameter int WID   = WID_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WID-1:0]   I0,
    input  logic [WID-1:0]   I1,
    input  logic [WID-1:0]   I2,
    output logic [WID-1:0]   OUT,
    output logic [2:0]       mismatch,
    output logic             all_agree,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt2
);

    logic [WID-1:0] out_q;
    logic [WID-1:0] out_d;
    logic [2:0]     mismatch_q;
    logic [2:0]     mismatch_d;
    logic           all_agree_q;
    logic           all_agree_d;

    // Vote each bit independently, then flag any replica that lost a vote on some bit.
    always_comb begin
        out_d = '0;
        for (int b = 0; b < WID; b++) begin
            out_d[b] = maj3(I0[b], I1[b], I2[b]);
        end
        mismatch_d[0] = |(I0 ^ out_d);
        mismatch_d[1] = |(I1 ^ out_d);
        mismatch_d[2] = |(I2 ^ out_d);
        all_agree_d   = ~(|mismatch_d);
    end

    // Output register: one cycle of latency, reset wins over the sampled inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            mismatch_q  <= 3'b000;
            all_agree_q <= 1'b1;
        end else begin
            out_q       <= out_d;
            mismatch_q  <= mismatch_d;
            all_agree_q <= all_agree_d;
        end
    end

    assign OUT       = out_q;
    assign mismatch  = mismatch_q;
    assign all_agree = all_agree_q;

`ifdef VOTE_ERR_CNT_EN
    tmr_sat_cnt #(.CNT_W(CNT_W)) u_cnt0 (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch_d[0]),
        .count (err_cnt0)
    );

    tmr_sat_cnt #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch_d[1]),
        .count (err_cnt1)
    );

    tmr_sat_cnt #(.CNT_W(CNT_W)) u_cnt2 (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch_d[2]),
        .count (err_cnt2)
    );
`else
    assign err_cnt0 = '0;
    assign err_cnt1 = '0;
    assign err_cnt2 = '0;
`endif

endmodule

// File: tb/tb_tmr_vote3.sv
// tb/tb_tmr_vote3.sv - table-driven self-checking bench for tmr_vote3
module tb_tmr_vote3;

    localparam int WID   = 5;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WID-1:0]   I0, I1, I2;
    logic [WID-1:0]   OUT;
    logic [2:0]       mismatch;
    logic             all_agree;
    logic [CNT_W-1:0] err_cnt0, err_cnt1, err_cnt2;

    int checks;
    int failures;

    tmr_vote3 #(.WID(WID), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .OUT       (OUT),
        .mismatch  (mismatch),
        .all_agree (all_agree),
        .err_cnt0  (err_cnt0),
        .err_cnt1  (err_cnt1),
        .err_cnt2  (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [WID-1:0] i0;
        logic [WID-1:0] i1;
        logic [WID-1:0] i2;
        logic [WID-1:0] out;
        logic [2:0]     mm;
        logic           agree;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vote(input string name, input logic [WID-1:0] out,
                            input logic [2:0] mm, input logic agree);
        chk({name, ".OUT"}, 32'(OUT), 32'(out));
        chk({name, ".mismatch"}, 32'(mismatch), 32'(mm));
        chk({name, ".all_agree"}, 32'(all_agree), 32'(agree));
    endtask

    task automatic chk_cnts(input string name, input int c0, input int c1, input int c2);
        chk({name, ".err_cnt0"}, 32'(err_cnt0), 32'(c0));
        chk({name, ".err_cnt1"}, 32'(err_cnt1), 32'(c1));
        chk({name, ".err_cnt2"}, 32'(err_cnt2), 32'(c2));
    endtask

    initial begin
        int exp2;
        checks   = 0;
        failures = 0;

        // Single-bit sweep, pattern named as I0 I1 I2.
        vecs.push_back('{"sw000", 5'h00, 5'h00, 5'h00, 5'h00, 3'b000, 1'b1});
        vecs.push_back('{"sw001", 5'h00, 5'h00, 5'h01, 5'h00, 3'b100, 1'b0});
        vecs.push_back('{"sw010", 5'h00, 5'h01, 5'h00, 5'h00, 3'b010, 1'b0});
        vecs.push_back('{"sw011", 5'h00, 5'h01, 5'h01, 5'h01, 3'b001, 1'b0});
        vecs.push_back('{"sw100", 5'h01, 5'h00, 5'h00, 5'h00, 3'b001, 1'b0});
        vecs.push_back('{"sw101", 5'h01, 5'h00, 5'h01, 5'h01, 3'b010, 1'b0});
        vecs.push_back('{"sw110", 5'h01, 5'h01, 5'h00, 5'h01, 3'b100, 1'b0});
        vecs.push_back('{"sw111", 5'h01, 5'h01, 5'h01, 5'h01, 3'b000, 1'b1});
        vecs.push_back('{"mixed", 5'h1F, 5'h00, 5'h0F, 5'h0F, 3'b011, 1'b0});
        vecs.push_back('{"perbit", 5'h01, 5'h02, 5'h03, 5'h03, 3'b011, 1'b0});
        vecs.push_back('{"three", 5'h03, 5'h05, 5'h06, 5'h07, 3'b111, 1'b0});
        vecs.push_back('{"allone", 5'h1F, 5'h1F, 5'h1F, 5'h1F, 3'b000, 1'b1});
        vecs.push_back('{"hiflip", 5'h10, 5'h00, 5'h10, 5'h10, 3'b010, 1'b0});

        // Reset held two cycles with disagreeing inputs.
        rst = 1'b1;
        I0 = 5'h15; I1 = 5'h0A; I2 = 5'h1F;
        tick();
        tick();
        chk_vote("reset", 5'h00, 3'b000, 1'b1);
        chk_cnts("reset", 0, 0, 0);
        rst = 1'b0;

        // Table: one vector per cycle, result visible one edge later.
        foreach (vecs[n]) begin
            I0 = vecs[n].i0; I1 = vecs[n].i1; I2 = vecs[n].i2;
            tick();
            chk_vote(vecs[n].name, vecs[n].out, vecs[n].mm, vecs[n].agree);
        end

        // Latency: a single-input change shows up on exactly the next edge.
        I0 = 5'h0A; I1 = 5'h0A; I2 = 5'h0A;
        tick();
        chk_vote("lat_base", 5'h0A, 3'b000, 1'b1);
        I1 = 5'h15;
        #2;
        chk_vote("lat_before", 5'h0A, 3'b000, 1'b1);
        tick();
        chk_vote("lat_after", 5'h0A, 3'b010, 1'b0);

        // Reset for one edge in the middle of disagreeing traffic.
        I0 = 5'h1F; I1 = 5'h00; I2 = 5'h0F;
        tick();
        chk_vote("mid_pre", 5'h0F, 3'b011, 1'b0);
        rst = 1'b1;
        tick();
        chk_vote("mid_rst", 5'h00, 3'b000, 1'b1);
        chk_cnts("mid_rst", 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_vote("mid_resume", 5'h0F, 3'b011, 1'b0);

        // Counters: clear, then I2 alone disagrees for five cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnts("cnt_clear", 0, 0, 0);
        I0 = 5'h00; I1 = 5'h00; I2 = 5'h04;
        for (int c = 1; c <= 5; c++) begin
            tick();
`ifdef VOTE_ERR_CNT_EN
            exp2 = (c > 3) ? 3 : c;
`else
            exp2 = 0;
`endif
            chk_cnts($sformatf("cnt_c%0d", c), 0, 0, exp2);
            chk_vote($sformatf("cnt_v%0d", c), 5'h00, 3'b100, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnts("cnt_rst", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr_vote3.md
Name: tmr_vote3

Overview:
- Bitwise triple-modular-redundancy (TMR) majority voter over three WID-bit words, I0/I1/I2.
- Each output bit is 1 when at least two of the three corresponding input bits are 1.
- The voted word and per-input disagreement flags are registered.
- Sits downstream of replicated logic to mask a single faulty copy and to report which copy disagreed.

Parameters:
- WID, 5, width of each voted word (>=1).
- CNT_W, 8, width of each per-input error counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- I0  input  WID  replica 0 word.
- I1  input  WID  replica 1 word.
- I2  input  WID  replica 2 word.
- OUT  output  WID  registered bitwise majority of I0/I1/I2.
- mismatch  output  3  registered flags; bit k=1 when Ik differs from the majority in any bit.
- all_agree  output  1  registered; 1 when I0==I1==I2.
- err_cnt0  output  CNT_W  saturating disagreement count for I0.
- err_cnt1  output  CNT_W  saturating disagreement count for I1.
- err_cnt2  output  CNT_W  saturating disagreement count for I2.

Behaviour:
- Combinational vote: maj = (I0&I1)|(I0&I2)|(I1&I2), bitwise over WID bits.
- Per-input disagreement: dk = |(Ik ^ maj) for k=0,1,2.
- Registered update: on each rising clk with rst=0, OUT<=maj, mismatch<={d2,d1,d0}, all_agree<=~(d0|d1|d2).
- Latency: exactly 1 cycle from input change to outputs. No handshake; the inputs are sampled every cycle.
- Reset: when rst=1 at a clock edge, OUT<=0, mismatch<=0, all_agree<=1, all err_cnt<=0. Reset takes priority over the sampled inputs.
- Reset asserted mid-stream: the outputs take their reset values at the next edge. Normal voting resumes on the first edge with rst=0.
- Per-bit independence: different bits may have different minority inputs. Example: I0=00001, I1=00010, I2=00011 gives OUT=00011 and mismatch=011.
- Mismatch combinations: two inputs can be flagged in the same cycle (on different bits), and all three can be flagged at once. all_agree is then 0.
- Inputs may be X-free only. No X propagation is required.

Optional Feature:
- Macro: VOTE_ERR_CNT_EN.
- When defined:
  - On each non-reset edge, err_cntk increments by 1 if dk=1.
  - The count saturates at 2^CNT_W-1 and does not wrap.
  - Reset clears the count to 0.
- When undefined:
  - The counter registers are not built.
  - err_cnt0/1/2 are driven constant 0.
  - The port list is unchanged.

Decomposition:
- Package tmr_vote_pkg: default WID and CNT_W constants, and a function maj3(a,b,c) returning the bitwise majority.
- One natural sub-module, tmr_sat_cnt: a CNT_W saturating counter with clk, rst, inc and count. It is instantiated three times under VOTE_ERR_CNT_EN.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> OUT=0, mismatch=000, all_agree=1, counters=0.
- Exhaustive 0/1 sweep: I0/I1/I2 each in {0,1}, all 8 combinations, one per 10 ns -> OUT=1 exactly for 011, 101, 110 and 111, one cycle later. For 001, mismatch=100; for 110, mismatch=100. For 000 and 111, all_agree=1.
- Mixed bits: I0=5'h1F, I1=5'h00, I2=5'h0F -> OUT=5'h0F, mismatch=011, all_agree=0.
- Latency: change the inputs from all 5'h0A to I1=5'h15 -> OUT stays 5'h0A. mismatch=010 exactly one edge after the change.
- Counters (macro on, CNT_W=2): hold I2 differing for 5 cycles -> err_cnt2 reads 1, 2, 3, 3, 3 while err_cnt0 and err_cnt1 stay 0. Assert rst -> all counters read 0.
- Reset mid-operation: rst=1 for one edge during disagreeing inputs -> the outputs take their reset values, and voting resumes on the next edge.
